// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int TAG_W     = 22;
  localparam int IDX_W     = 5;
  localparam int OFS_W     = 3;
  localparam int LINE_BITS = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Line storage: tag/valid/dirty plus line data, combinational read,
// synchronous full-line fill or single-word store.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256,
  parameter int TAG_BITS  = 22,
  parameter int IDX_BITS  = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_BITS-1:0] idx_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_BITS-1:0] tag_o,
  output logic [LINE_W-1:0]   line_o,
  input  logic                line_we_i,
  input  logic [TAG_BITS-1:0] tag_i,
  input  logic [LINE_W-1:0]   line_i,
  input  logic                word_we_i,
  input  logic [OFS_W-1:0]    word_sel_i,
  input  logic [31:0]         word_i
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
    end else if (word_we_i) begin
      dirty_d[idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= line_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller:
// hit detection, miss FSM and line-granular memory interface.
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
);
  import dcache_pkg::*;

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - 5 - IW;

  state_e state_q, state_d;

  logic [IW-1:0]        idx;
  logic [TW-1:0]        tag;
  logic [OFS_W-1:0]     ofs;
  logic                 line_valid;
  logic                 line_dirty;
  logic [TW-1:0]        line_tag;
  logic [LINE_BITS-1:0] line_data;
  logic                 hit;
  logic                 line_we;
  logic                 word_we;
  logic [31:0]          hit_word;
  logic                 unused_addr;

  assign unused_addr = ^addr_i[1:0];

  assign idx = addr_i[5 +: IW];
  assign tag = addr_i[31 -: TW];
  assign ofs = addr_i[2 +: OFS_W];

  assign hit      = req_i && line_valid && (line_tag == tag);
  assign hit_word = line_data[{ofs, 5'b0} +: 32];
  assign rdata_o  = (hit && !we_i) ? hit_word : 32'd0;
  assign word_we  = hit && we_i && (state_q == IDLE);
  // Held low in reset even though a request may be pending.
  assign stall_o  = rst_i && ((state_q != IDLE) || (req_i && !hit));

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_BITS),
    .TAG_BITS  (TW),
    .IDX_BITS  (IW)
  ) u_array (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (idx),
    .valid_o    (line_valid),
    .dirty_o    (line_dirty),
    .tag_o      (line_tag),
    .line_o     (line_data),
    .line_we_i  (line_we),
    .tag_i      (tag),
    .line_i     (mem_rdata_i),
    .word_we_i  (word_we),
    .word_sel_i (ofs),
    .word_i     (wdata_i)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = '0;
    line_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && !hit) begin
          state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {line_tag, idx, 5'b0};
        mem_wdata_o = line_data;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_i[31:5], 5'b0};
        if (mem_ack_i) begin
          line_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural line memory whose ack
// delay is programmable (delay d means d wait cycles before the ack cycle).
module tb_dcache_ctrl;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  logic         clk;
  logic         rst_i;
  logic         req_i;
  logic         we_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic         mem_ack_i;
  logic [255:0] mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;
  int ack_delay = 0;
  bit model_en = 1;

  logic [255:0] mem_q [logic [31:0]];
  txn_t         log_q [$];

  dcache_ctrl #(.NUM_LINES(32), .LINE_BITS(256)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Unwritten lines read back as (address of word) ^ 0x1357_0000.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem_q.exists(a)) return mem_q[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (a + 32'(w * 4)) ^ 32'h1357_0000;
    return l;
  endfunction

  // Memory model: acks after ack_delay wait cycles, checks request stability
  // and that mem_req_o drops the cycle after a fetch completes.
  initial begin : mem_model
    bit           in_txn;
    bit           post_fetch;
    int           wait_cnt;
    logic         t_we;
    logic [31:0]  t_addr;
    logic [255:0] t_wdata;
    in_txn = 0; post_fetch = 0; wait_cnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!model_en) continue;
      mem_ack_i = 1'b0;
      if (!rst_i) begin
        in_txn = 0;
        post_fetch = 0;
        continue;
      end
      if (post_fetch) begin
        n_cmp++;
        if (mem_req_o !== 1'b0) begin
          n_err++;
          $display("FAIL req_after_ack: mem_req_o=%b required 0", mem_req_o);
        end
        post_fetch = 0;
      end
      if (mem_req_o === 1'b1) begin
        if (!in_txn) begin
          in_txn = 1; wait_cnt = 0;
          t_we = mem_we_o; t_addr = mem_addr_o; t_wdata = mem_wdata_o;
        end else begin
          n_cmp++;
          if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {t_we, t_addr, t_wdata}) begin
            n_err++;
            $display("FAIL req_stable: we=%b addr=%h required we=%b addr=%h", mem_we_o, mem_addr_o, t_we, t_addr);
          end
        end
        if (wait_cnt == ack_delay) begin
          mem_ack_i = 1'b1;
          if (t_we) mem_q[t_addr] = t_wdata;
          else mem_rdata_i = line_of(t_addr);
          log_q.push_back('{we: t_we, addr: t_addr, data: t_wdata});
          in_txn = 0;
          post_fetch = !t_we;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // One CPU access: counts stall cycles, returns the data seen in the hit cycle.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stalls);
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    #1;
    stalls = 0;
    while (stall_o === 1'b1 && stalls < 400) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL access_timeout: stall_o=%b after %0d cycles required 0", stall_o, stalls);
    end
    rd = rdata_o;
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL mem_req_in_hit: mem_req_o=%b required 0", mem_req_o);
    end
    $display("access we=%b addr=%h wdata=%h rdata=%h stalls=%0d", we, a, d, rd, stalls);
    @(posedge clk);
    #1;
    req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0104; wdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b required 0", stall_o); end
    n_cmp++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mem_ctl: req=%b we=%b required 0 0", mem_req_o, mem_we_o);
    end
    n_cmp++;
    if (mem_addr_o !== 32'd0) begin n_err++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr_o); end
    n_cmp++;
    if (mem_wdata_o !== 256'd0) begin n_err++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata_o); end
    n_cmp++;
    if (rdata_o !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h required 0", rdata_o); end
    req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_cold_load();
    logic [31:0] rd;
    int st;
    ack_delay = 0;
    log_q.delete();
    access(1'b0, 32'h0000_0104, 32'd0, rd, st);
    n_cmp++;
    if (st !== 2) begin n_err++; $display("FAIL cold_stalls: got %0d required 2", st); end
    n_cmp++;
    if (rd !== 32'h1357_0104) begin n_err++; $display("FAIL cold_rdata: got %h required 13570104", rd); end
    n_cmp++;
    if (log_q.size() != 1 || log_q[0].we !== 1'b0 || log_q[0].addr !== 32'h0000_0100) begin
      n_err++; $display("FAIL cold_txn: count=%0d required one fetch at 00000100", log_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int st;
    log_q.delete();
    access(1'b0, 32'h0000_0108, 32'd0, rd, st);
    n_cmp++;
    if (st !== 0) begin n_err++; $display("FAIL b2b_stalls: got %0d required 0", st); end
    n_cmp++;
    if (rd !== 32'h1357_0108) begin n_err++; $display("FAIL b2b_rdata: got %h required 13570108", rd); end
    n_cmp++;
    if (log_q.size() != 0) begin n_err++; $display("FAIL b2b_no_mem: got %0d txns required 0", log_q.size()); end
  endtask

  task automatic test_writeback();
    logic [31:0] rd;
    int st;
    access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, rd, st);
    n_cmp++;
    if (st !== 0) begin n_err++; $display("FAIL store_hit_stalls: got %0d required 0", st); end
    log_q.delete();
    access(1'b0, 32'h0000_0500, 32'd0, rd, st);
    n_cmp++;
    if (st !== 3) begin n_err++; $display("FAIL dirty_stalls: got %0d required 3", st); end
    n_cmp++;
    if (rd !== 32'h1357_0500) begin n_err++; $display("FAIL dirty_rdata: got %h required 13570500", rd); end
    n_cmp++;
    if (log_q.size() != 2) begin
      n_err++; $display("FAIL dirty_txn_count: got %0d required 2", log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0].we !== 1'b1 || log_q[0].addr !== 32'h0000_0100) begin
        n_err++; $display("FAIL wb_addr: we=%b addr=%h required 1 00000100", log_q[0].we, log_q[0].addr);
      end
      n_cmp++;
      if (log_q[0].data[63:0] !== 64'h1357_0104_DEAD_BEEF) begin
        n_err++; $display("FAIL wb_data: got %h required 13570104deadbeef", log_q[0].data[63:0]);
      end
      n_cmp++;
      if (log_q[1].we !== 1'b0 || log_q[1].addr !== 32'h0000_0500) begin
        n_err++; $display("FAIL alloc_addr: we=%b addr=%h required 0 00000500", log_q[1].we, log_q[1].addr);
      end
    end
    access(1'b0, 32'h0000_0100, 32'd0, rd, st);
    n_cmp++;
    if (st !== 2) begin n_err++; $display("FAIL refetch_stalls: got %0d required 2", st); end
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL refetch_rdata: got %h required deadbeef", rd); end
  endtask

  task automatic test_store_miss();
    logic [31:0] rd;
    int st;
    access(1'b1, 32'h0000_0300, 32'hCAFE_F00D, rd, st);
    n_cmp++;
    if (st !== 2) begin n_err++; $display("FAIL store_miss_stalls: got %0d required 2", st); end
    access(1'b0, 32'h0000_0300, 32'd0, rd, st);
    n_cmp++;
    if (st !== 0 || rd !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL store_merge: stalls=%0d rdata=%h required 0 cafef00d", st, rd);
    end
    access(1'b0, 32'h0000_0304, 32'd0, rd, st);
    n_cmp++;
    if (st !== 0 || rd !== 32'h1357_0304) begin
      n_err++; $display("FAIL store_neighbour: stalls=%0d rdata=%h required 0 13570304", st, rd);
    end
  endtask

  task automatic test_latency7();
    logic [31:0] rd;
    int st;
    ack_delay = 7;
    access(1'b0, 32'h0000_0200, 32'd0, rd, st);
    n_cmp++;
    if (st !== 9) begin n_err++; $display("FAIL lat7_clean_stalls: got %0d required 9", st); end
    n_cmp++;
    if (rd !== 32'h1357_0200) begin n_err++; $display("FAIL lat7_clean_rdata: got %h required 13570200", rd); end
    access(1'b1, 32'h0000_0204, 32'h1234_5678, rd, st);
    log_q.delete();
    access(1'b0, 32'h0400_0200, 32'd0, rd, st);
    n_cmp++;
    if (st !== 17) begin n_err++; $display("FAIL lat7_dirty_stalls: got %0d required 17", st); end
    n_cmp++;
    if (rd !== 32'h1757_0200) begin n_err++; $display("FAIL lat7_dirty_rdata: got %h required 17570200", rd); end
    n_cmp++;
    if (log_q.size() != 2 || log_q[0].addr !== 32'h0000_0200 || log_q[0].data[63:32] !== 32'h1234_5678
        || log_q[1].addr !== 32'h0400_0200) begin
      n_err++; $display("FAIL lat7_txns: count=%0d required wb 00000200 word1 12345678 then fetch 04000200", log_q.size());
    end
    ack_delay = 0;
  endtask

  task automatic test_spurious_ack();
    logic [31:0] rd;
    int st;
    @(negedge clk);
    model_en = 0;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0000_0300;
    mem_ack_i = 1'b1; mem_rdata_i = '1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_err++; $display("FAIL spurious_idle: stall=%b req=%b required 0 0", stall_o, mem_req_o);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL spurious_state: mem_req_o=%b required 0", mem_req_o); end
    model_en = 1;
    access(1'b0, 32'h0000_0300, 32'd0, rd, st);
    n_cmp++;
    if (st !== 0 || rd !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL spurious_line: stalls=%0d rdata=%h required 0 cafef00d", st, rd);
    end
  endtask

  task automatic test_reset_mid_alloc();
    logic [31:0] rd;
    int st;
    ack_delay = 7;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0208;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0200) begin
      n_err++; $display("FAIL mid_alloc_req: req=%b addr=%h required 1 00000200", mem_req_o, mem_addr_o);
    end
    #1;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_addr_o !== 32'd0) begin
      n_err++; $display("FAIL async_rst: req=%b stall=%b addr=%h required 0 0 0", mem_req_o, stall_o, mem_addr_o);
    end
    req_i = 1'b0;
    @(negedge clk);
    #3;
    ack_delay = 0;
    rst_i = 1'b1;
    access(1'b0, 32'h0000_0208, 32'd0, rd, st);
    n_cmp++;
    if (st !== 2 || rd !== 32'h1357_0208) begin
      n_err++; $display("FAIL post_rst_miss: stalls=%0d rdata=%h required 2 13570208", st, rd);
    end
    access(1'b0, 32'h0000_0300, 32'd0, rd, st);
    n_cmp++;
    if (st !== 2 || rd !== 32'h1357_0300) begin
      n_err++; $display("FAIL post_rst_dirty_lost: stalls=%0d rdata=%h required 2 13570300", st, rd);
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_back_to_back();
    test_writeback();
    test_store_miss();
    test_latency7();
    test_spurious_ack();
    test_reset_mid_alloc();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
